// File: rtl/setuphold_q_checker.sv
// Checks a flop's q against its d stream delayed by LAT edges.
// Counts mismatches (X/Z included) and records the index of the first one.
module setuphold_q_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             d_exp,
    input  logic             q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    state_t           state;
    state_t           state_nxt;
    logic [LAT-1:0]   sr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] num;
    logic             mism;
    logic             last_fill;
    logic             last_cmp;

    // Case inequality so an X/Z on q is flagged rather than masked.
    assign mism      = (q !== sr[LAT-1]);
    assign last_fill = (cnt == FILL_LAST);
    assign last_cmp  = (cnt == num - 1'b1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (last_fill)
                    state_nxt = (num == '0) ? DONE : CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (last_cmp) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= d_exp;
            for (int i = 1; i < LAT; i++)
                sr[i] <= sr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            num           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt           <= '0;
            num           <= num_cycles;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
        end else if (state == FILL) begin
            cnt <= last_fill ? '0 : cnt + 1'b1;
        end else if (state == CHECK) begin
            cnt <= cnt + 1'b1;
            if (mism) begin
                if (err_count != ERR_MAX)
                    err_count <= err_count + 1'b1;
                if (!first_err_vld) begin
                    first_err_idx <= cnt;
                    first_err_vld <= 1'b1;
                end
            end
        end else if (state == DONE) begin
            pass <= (err_count == '0);
        end
    end

endmodule

// File: tb/tb_setuphold_q_checker.sv
// Directed bench for setuphold_q_checker (LAT=1 and LAT=3 instances).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_setuphold_q_checker;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic          d_exp = 1'b0;
    logic          q = 1'b0;
    logic          busy, done, first_err_vld, pass;
    logic [CW-1:0] err_count, first_err_idx;

    logic          start3 = 1'b0;
    logic [CW-1:0] num3 = '0;
    logic          d3 = 1'b0;
    logic          q3 = 1'b0;
    logic          busy3, done3, vld3, pass3;
    logic [CW-1:0] err3, idx3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    setuphold_q_checker #(.LAT(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_cycles(num_cycles), .d_exp(d_exp), .q(q),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld), .pass(pass)
    );

    setuphold_q_checker #(.LAT(3), .CNT_W(CW)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .num_cycles(num3), .d_exp(d3), .q(q3),
        .busy(busy3), .done(done3), .err_count(err3),
        .first_err_idx(idx3),
        .first_err_vld(vld3), .pass(pass3)
    );

    // One LAT=1 run: d_exp toggles every cycle, q follows it one edge late,
    // optionally flipped at bad_a/bad_b, X at xi, or always inverted.
    task automatic run1(input int n, input int bad_a, input int bad_b,
                        input int xi, input bit inv,
                        output int nbusy, output int ndone);
        logic prev;
        int   k;
        nbusy = 0;
        ndone = 0;
        d_exp = 1'b0;
        num_cycles = CW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 0; w < n + 4; w++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            prev  = d_exp;
            d_exp = ~d_exp;
            k = w - 1;
            if (k == xi)                    q = 1'bx;
            else if (k == bad_a || k == bad_b) q = ~prev;
            else                            q = inv ? ~prev : prev;
            @(posedge clk); #1;
        end
        q = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, err_count, first_err_idx, first_err_vld, pass} !== '0) begin
            errors++;
            $display("FAIL reset_lat1: got %b%b %0d %0d %b%b, want all 0",
                     busy, done, err_count, first_err_idx, first_err_vld, pass);
        end
        checks++;
        if ({busy3, done3, err3, idx3, vld3, pass3} !== '0) begin
            errors++;
            $display("FAIL reset_lat3: outputs not all 0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        int nb, nd;
        run1(8, -1, -1, -1, 1'b0, nb, nd);
        checks++;
        if (nb !== 9) begin errors++; $display("FAIL clean_busy: got %0d want 9", nb); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL clean_done: got %0d want 1", nd); end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", err_count); end
        checks++;
        if (first_err_vld !== 1'b0) begin errors++; $display("FAIL clean_vld: got %b want 0", first_err_vld); end
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b want 1", pass); end
    endtask

    task automatic test_errors();
        int nb, nd;
        run1(8, 3, 6, -1, 1'b0, nb, nd);
        checks++;
        if (err_count !== 8'd2) begin errors++; $display("FAIL errs_count: got %0d want 2", err_count); end
        checks++;
        if (first_err_idx !== 8'd3) begin errors++; $display("FAIL errs_idx: got %0d want 3", first_err_idx); end
        checks++;
        if (first_err_vld !== 1'b1) begin errors++; $display("FAIL errs_vld: got %b want 1", first_err_vld); end
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL errs_pass: got %b want 0", pass); end
    endtask

    task automatic test_xq();
        int nb, nd;
        run1(8, -1, -1, 0, 1'b0, nb, nd);
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL xq_count: got %0d want 1", err_count); end
        checks++;
        if (first_err_idx !== 8'd0 || first_err_vld !== 1'b1) begin
            errors++;
            $display("FAIL xq_idx: got %0d/%b want 0/1", first_err_idx, first_err_vld);
        end
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL xq_pass: got %b want 0", pass); end
    endtask

    task automatic test_saturate();
        int nb, nd;
        run1(255, -1, -1, -1, 1'b1, nb, nd);
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", err_count); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL sat_done: got %0d want 1", nd); end
        checks++;
        if (pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b want 0", pass); end
    endtask

    task automatic test_zero();
        int nb, nd;
        run1(0, -1, -1, -1, 1'b1, nb, nd);
        checks++;
        if (nb !== 1) begin errors++; $display("FAIL zero_busy: got %0d want 1", nb); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL zero_done: got %0d want 1", nd); end
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL zero_err: got %0d want 0", err_count); end
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b want 1", pass); end
    endtask

    task automatic test_abort();
        logic prev;
        int   nb, nd, bad;
        d_exp = 1'b0;
        num_cycles = 8'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 0; w < 5; w++) begin
            prev  = d_exp;
            d_exp = ~d_exp;
            q = (w == 2) ? ~prev : prev;
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_pre: busy %b err %0d want 1/1", busy, err_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err_count, first_err_idx, first_err_vld, pass} !== '0) begin
            errors++;
            $display("FAIL abort_async: busy %b done %b err %0d idx %0d vld %b pass %b want 0",
                     busy, done, err_count, first_err_idx, first_err_vld, pass);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_hold: %0d bad cycles want 0", bad); end
        rst_n = 1'b1;
        q = 1'b0;
        run1(8, -1, -1, -1, 1'b0, nb, nd);
        checks++;
        if (nd !== 1 || pass !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_rerun: done %0d pass %b err %0d want 1/1/0", nd, pass, err_count);
        end
    endtask

    task automatic test_hold();
        int   nd;
        logic d5, b6, b7;
        nd = 0;
        d5 = 1'b0; b6 = 1'b1; b7 = 1'b0;
        d3 = 1'b0;
        q3 = 1'b0;
        num3 = 8'd2;
        start3 = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < 21; w++) begin
            if (done3) nd++;
            if (w == 5) d5 = done3;
            if (w == 6) b6 = busy3;
            if (w == 7) b7 = busy3;
            @(posedge clk); #1;
        end
        start3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (nd !== 3) begin errors++; $display("FAIL hold_runs: got %0d done pulses want 3", nd); end
        checks++;
        if (d5 !== 1'b1) begin errors++; $display("FAIL hold_done_time: got %b want 1", d5); end
        checks++;
        if (b6 !== 1'b0) begin errors++; $display("FAIL hold_idle_gap: got %b want 0", b6); end
        checks++;
        if (b7 !== 1'b1) begin errors++; $display("FAIL hold_restart: got %b want 1", b7); end
        checks++;
        if (pass3 !== 1'b1 || err3 !== 8'd0) begin
            errors++;
            $display("FAIL hold_pass: pass %b err %0d want 1/0", pass3, err3);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_xq();
        test_saturate();
        test_zero();
        test_abort();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
